my_pe_ctrl: RTL and testbench

- Initiator-side sequencer for the processing element (PE) that has a local RAM and a multiply-accumulate (MAC) datapath.
- Loads one operand vector B into the PE RAM through the PE write port.
- Then streams vector A one element at a time through the PE valid/dvalid handshake and returns the final dot product to the host.
- Sits between the host-side streams and a single PE instance; drives every PE input.

---
 rtl/my_pe_ctrl_if.sv | 51 +++++
 rtl/my_pe_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_my_pe_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/my_pe_ctrl_if.sv
// my_pe_ctrl_if: bundles the host-side streams and the PE-side bus of my_pe_ctrl.
//
// Parameters:
//   SIZE        data width of A, B and the result
//   L_RAM_SIZE  PE RAM address width
//
// Modports:
//   master  the controller (drives ready/result/status and every PE input)
//   slave   the environment (host streams plus the PE instance)
//
// Signals:
//   start, b_data/b_valid/b_ready, a_data/a_valid/a_ready   host side
//   res_data/res_valid, busy, err                           result/status
//   pe_aresetn, pe_din, pe_addr, pe_we, pe_ain, pe_valid    to PE
//   pe_dvalid, pe_dout                                      from PE
interface my_pe_ctrl_if #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned L_RAM_SIZE = 3
);
    logic                  start;
    logic [SIZE-1:0]       b_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [SIZE-1:0]       a_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [SIZE-1:0]       res_data;
    logic                  res_valid;
    logic                  busy;
    logic                  err;
    logic                  pe_aresetn;
    logic [SIZE-1:0]       pe_din;
    logic [L_RAM_SIZE-1:0] pe_addr;
    logic                  pe_we;
    logic [SIZE-1:0]       pe_ain;
    logic                  pe_valid;
    logic                  pe_dvalid;
    logic [SIZE-1:0]       pe_dout;

    modport master (
        input  start, b_data, b_valid, a_data, a_valid, pe_dvalid, pe_dout,
        output b_ready, a_ready, res_data, res_valid, busy, err,
               pe_aresetn, pe_din, pe_addr, pe_we, pe_ain, pe_valid
    );

    modport slave (
        output start, b_data, b_valid, a_data, a_valid, pe_dvalid, pe_dout,
        input  b_ready, a_ready, res_data, res_valid, busy, err,
               pe_aresetn, pe_din, pe_addr, pe_we, pe_ain, pe_valid
    );
endinterface

// File: rtl/my_pe_ctrl.sv
// my_pe_ctrl: initiator-side sequencer for a PE with local RAM and a MAC datapath.
// Loads vector B into the PE RAM, then streams vector A one element at a time
// through the PE valid/dvalid handshake and returns the final dot product.
//
// Ports:
//   aclk    clock
//   areset  synchronous active-high reset
//   bus     my_pe_ctrl_if.master (host streams, result/status, PE bus)
//
// Optional feature: define PE_CTRL_TIMEOUT_EN to enable a pe_dvalid watchdog of
// TIMEOUT_CYC cycles that sets the sticky err flag and ends the job with
// res_data = 0. Without it, err is tied 0 and WAIT waits indefinitely.
module my_pe_ctrl #(
    parameter int unsigned SIZE        = 8,
    parameter int unsigned L_RAM_SIZE  = 3,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic         aclk,
    input  logic         areset,
    my_pe_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLR     = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_FETCH_A = 3'd3;
    localparam logic [2:0] S_RD      = 3'd4;
    localparam logic [2:0] S_ISSUE   = 3'd5;
    localparam logic [2:0] S_WAIT    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [L_RAM_SIZE-1:0] K_LAST = {L_RAM_SIZE{1'b1}};

    logic [2:0]            state_q, state_d;
    logic [L_RAM_SIZE-1:0] k_q, k_d;
    logic [L_RAM_SIZE-1:0] pe_addr_q, pe_addr_d;
    logic [SIZE-1:0]       pe_din_q, pe_din_d;
    logic [SIZE-1:0]       pe_ain_q, pe_ain_d;
    logic [SIZE-1:0]       res_data_q, res_data_d;
    logic                  pe_aresetn_q, pe_aresetn_d;
    logic                  pe_we_q, pe_we_d;
    logic                  pe_valid_q, pe_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  a_ready_q, a_ready_d;
    logic                  res_valid_q, res_valid_d;
    logic                  busy_q, busy_d;

`ifdef PE_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // ISSUE occupies one cycle and DONE follows the last WAIT cycle, so WAIT
    // lasts TIMEOUT_CYC-1 cycles and DONE lands TIMEOUT_CYC cycles after ISSUE.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        pe_addr_d   = pe_addr_q;
        pe_din_d    = pe_din_q;
        pe_ain_d    = pe_ain_q;
        res_data_d  = res_data_q;
        b_ready_d   = b_ready_q;
        a_ready_d   = a_ready_q;
        pe_we_d     = 1'b0;
        pe_valid_d  = 1'b0;
        res_valid_d = 1'b0;
`ifdef PE_CTRL_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLR;
`ifdef PE_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLR: begin
                k_d       = '0;
                b_ready_d = 1'b1;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                // b_ready low inside LOAD means the last write is on the bus now.
                if (!b_ready_q) begin
                    a_ready_d = 1'b1;
                    state_d   = S_FETCH_A;
                end else if (bus.b_valid) begin
                    pe_we_d   = 1'b1;
                    pe_addr_d = k_q;
                    pe_din_d  = bus.b_data;
                    k_d       = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        b_ready_d = 1'b0;
                    end
                end
            end
            S_FETCH_A: begin
                if (bus.a_valid && a_ready_q) begin
                    pe_ain_d  = bus.a_data;
                    pe_addr_d = k_q;
                    a_ready_d = 1'b0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                pe_valid_d = 1'b1;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef PE_CTRL_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                if (bus.pe_dvalid) begin
                    if (k_q == K_LAST) begin
                        res_data_d  = bus.pe_dout;
                        res_valid_d = 1'b1;
                        k_d         = '0;
                        state_d     = S_DONE;
                    end else begin
                        k_d       = k_q + 1'b1;
                        a_ready_d = 1'b1;
                        state_d   = S_FETCH_A;
                    end
                end
`ifdef PE_CTRL_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d       = 1'b1;
                    res_data_d  = '0;
                    res_valid_d = 1'b1;
                    k_d         = '0;
                    state_d     = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pe_aresetn_d = (state_d != S_CLR);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            pe_addr_q    <= '0;
            pe_din_q     <= '0;
            pe_ain_q     <= '0;
            res_data_q   <= '0;
            pe_aresetn_q <= 1'b0;
            pe_we_q      <= 1'b0;
            pe_valid_q   <= 1'b0;
            b_ready_q    <= 1'b0;
            a_ready_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PE_CTRL_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            pe_addr_q    <= pe_addr_d;
            pe_din_q     <= pe_din_d;
            pe_ain_q     <= pe_ain_d;
            res_data_q   <= res_data_d;
            pe_aresetn_q <= pe_aresetn_d;
            pe_we_q      <= pe_we_d;
            pe_valid_q   <= pe_valid_d;
            b_ready_q    <= b_ready_d;
            a_ready_q    <= a_ready_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
`ifdef PE_CTRL_TIMEOUT_EN
            tmo_q        <= tmo_d;
            err_q        <= err_d;
`endif
        end
    end

    assign bus.b_ready    = b_ready_q;
    assign bus.a_ready    = a_ready_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.busy       = busy_q;
    assign bus.pe_aresetn = pe_aresetn_q;
    assign bus.pe_din     = pe_din_q;
    assign bus.pe_addr    = pe_addr_q;
    assign bus.pe_we      = pe_we_q;
    assign bus.pe_ain     = pe_ain_q;
    assign bus.pe_valid   = pe_valid_q;
`ifdef PE_CTRL_TIMEOUT_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_my_pe_ctrl.sv
// Testbench for my_pe_ctrl: directed jobs against a behavioural PE model
// (RAM + MAC with a per-element latency table; latency 0 means never respond).
module tb_my_pe_ctrl;
    localparam int unsigned SIZE = 8;
    localparam int unsigned LRS  = 3;
    localparam int unsigned TMO  = 64;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    my_pe_ctrl_if #(.SIZE(SIZE), .L_RAM_SIZE(LRS)) bus ();

    my_pe_ctrl #(.SIZE(SIZE), .L_RAM_SIZE(LRS), .TIMEOUT_CYC(TMO)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus configuration
    logic [7:0] bvec [8];
    logic [7:0] avec [8];
    int         lat_tab [8];
    bit         stall = 1'b0;
    bit         start_mid = 1'b0;

    // PE model
    logic [7:0] ram [8];
    logic [7:0] acc, prod;
    int         cnt, m_idx;

    always @(posedge aclk) begin
        if (bus.pe_we) ram[bus.pe_addr] <= bus.pe_din;
        if (!bus.pe_aresetn) begin
            acc           <= 8'd0;
            cnt           <= 0;
            m_idx         <= 0;
            bus.pe_dvalid <= 1'b0;
            bus.pe_dout   <= 8'd0;
        end else begin
            bus.pe_dvalid <= 1'b0;
            if (bus.pe_dvalid) acc <= bus.pe_dout;
            if (bus.pe_valid) begin
                prod  <= bus.pe_ain * ram[bus.pe_addr];
                cnt   <= lat_tab[m_idx[2:0]];
                m_idx <= m_idx + 1;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end else if (cnt == 1) begin
                cnt           <= 0;
                bus.pe_dvalid <= 1'b1;
                bus.pe_dout   <= acc + prod;
            end
        end
    end

    // Bus monitor, sampled on the falling edge
    int         cyc = 0, we_cnt = 0, vld_cnt = 0, res_cnt = 0;
    int         multi_viol = 0, addr_err = 0, busy_err = 0;
    int         clr_cnt = 0, low_run = 0, last_low = 0, issue_idx = 0;
    int         last_issue_cyc = 0, last_res_cyc = 0;
    bit         outstanding = 1'b0, prev_rv = 1'b0, rec_err = 1'b0;
    logic [7:0] rec_res = 8'd0;
    logic [2:0] issue_addr = 3'd0;
    logic [2:0] we_log [$];

    always @(negedge aclk) begin
        cyc++;
        if (prev_rv && bus.busy) busy_err++;
        prev_rv = bus.res_valid;
        if (bus.res_valid) begin
            res_cnt++;
            rec_res      = bus.res_data;
            rec_err      = bus.err;
            last_res_cyc = cyc;
        end
        if (bus.pe_we) begin
            we_cnt++;
            we_log.push_back(bus.pe_addr);
        end
        if (!bus.pe_aresetn) begin
            low_run++;
            outstanding = 1'b0;
            issue_idx   = 0;
        end else begin
            if (low_run > 0) begin
                last_low = low_run;
                clr_cnt++;
            end
            low_run = 0;
            if (outstanding && bus.pe_addr !== issue_addr) addr_err++;
            if (bus.pe_valid) begin
                vld_cnt++;
                last_issue_cyc = cyc;
                if (outstanding) multi_viol++;
                if (bus.pe_addr !== 3'(issue_idx)) addr_err++;
                outstanding = 1'b1;
                issue_addr  = bus.pe_addr;
                issue_idx++;
            end
            if (bus.pe_dvalid) outstanding = 1'b0;
        end
    end

    // Runs one job; abort_k >= 0 stops driving once element abort_k is in WAIT.
    task automatic run_job(input int abort_k, output logic [7:0] res, output bit got);
        int bi, ai, n, r0;
        bit bacc, aacc, mid_done;
        bi = 0; ai = 0; n = 0; r0 = res_cnt; mid_done = 1'b0;
        @(negedge aclk);
        bus.start = 1'b1;
        @(negedge aclk);
        bus.start = 1'b0;
        while (res_cnt == r0 && n < 3000) begin
            if (abort_k >= 0 && outstanding && issue_idx == abort_k + 1) break;
            bus.start = start_mid && !mid_done && bi == 3;
            if (bus.start) mid_done = 1'b1;
            bus.b_valid = (bi < 8) && (!stall || $urandom_range(1, 0) == 1);
            bus.b_data  = bvec[bi[2:0]];
            bus.a_valid = (ai < 8) && (!stall || $urandom_range(1, 0) == 1);
            bus.a_data  = avec[ai[2:0]];
            bacc = bus.b_valid && bus.b_ready;
            aacc = bus.a_valid && bus.a_ready;
            @(negedge aclk);
            n++;
            if (bacc) bi++;
            if (aacc) ai++;
        end
        bus.start   = 1'b0;
        bus.b_valid = 1'b0;
        bus.a_valid = 1'b0;
        got = (res_cnt != r0);
        res = rec_res;
    endtask

    task automatic set_vectors(input int a_const, input int b_const, input int lat);
        for (int i = 0; i < 8; i++) begin
            bvec[i]    = (b_const < 0) ? 8'(i + 1) : 8'(b_const);
            avec[i]    = 8'(a_const);
            lat_tab[i] = lat;
        end
    endtask

    task automatic test_reset;
        logic [34:0] ov;
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        ov = {bus.pe_aresetn, bus.pe_we, bus.pe_valid, bus.b_ready, bus.a_ready,
              bus.res_valid, bus.err, bus.busy, bus.pe_addr, bus.pe_din, bus.pe_ain,
              bus.res_data};
        checks++;
        if (ov !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", ov);
        end
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if ({bus.pe_aresetn, bus.busy, bus.b_ready} !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle: aresetn/busy/b_ready=%b expected 100",
                     {bus.pe_aresetn, bus.busy, bus.b_ready});
        end
    endtask

    task automatic test_basic;
        logic [7:0] r;
        bit got;
        int v0, r0, b0;
        set_vectors(1, -1, 3);
        stall = 1'b0; start_mid = 1'b0;
        v0 = vld_cnt; r0 = res_cnt; b0 = busy_err;
        run_job(-1, r, got);
        repeat (3) @(negedge aclk);
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL basic_done: got %0d expected 1", got); end
        checks++;
        if (r !== 8'd36) begin errors++; $display("FAIL basic_result: got %0d expected 36", r); end
        checks++;
        if (res_cnt - r0 !== 1) begin
            errors++; $display("FAIL basic_res_pulses: got %0d expected 1", res_cnt - r0);
        end
        checks++;
        if (vld_cnt - v0 !== 8) begin
            errors++; $display("FAIL basic_pe_valid: got %0d expected 8", vld_cnt - v0);
        end
        checks++;
        if (busy_err - b0 !== 0) begin
            errors++; $display("FAIL basic_busy_after_done: got %0d expected 0", busy_err - b0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] r;
        bit got;
        int c0;
        set_vectors(3, 2, 3);
        stall = 1'b0; start_mid = 1'b1;
        c0 = clr_cnt;
        run_job(-1, r, got);
        checks++;
        if (r !== 8'd48 || !got) begin errors++; $display("FAIL b2b_job1: got %0d expected 48", r); end
        checks++;
        if (clr_cnt - c0 !== 1 || last_low !== 1) begin
            errors++;
            $display("FAIL b2b_clr1: pulses %0d width %0d expected 1 1", clr_cnt - c0, last_low);
        end
        start_mid = 1'b0;
        set_vectors(1, 1, 3);
        c0 = clr_cnt;
        run_job(-1, r, got);
        checks++;
        if (r !== 8'd8 || !got) begin errors++; $display("FAIL b2b_job2: got %0d expected 8", r); end
        checks++;
        if (clr_cnt - c0 !== 1 || last_low !== 1) begin
            errors++;
            $display("FAIL b2b_clr2: pulses %0d width %0d expected 1 1", clr_cnt - c0, last_low);
        end
    endtask

    task automatic test_stalled;
        logic [7:0] r;
        bit got;
        int w0, s0;
        set_vectors(1, -1, 3);
        stall = 1'b1;
        w0 = we_cnt; s0 = we_log.size();
        run_job(-1, r, got);
        stall = 1'b0;
        checks++;
        if (r !== 8'd36 || !got) begin errors++; $display("FAIL stall_result: got %0d expected 36", r); end
        checks++;
        if (we_cnt - w0 !== 8) begin
            errors++; $display("FAIL stall_we_count: got %0d expected 8", we_cnt - w0);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (s0 + j >= we_log.size()) begin
                errors++; $display("FAIL stall_we_addr%0d: missing expected %0d", j, j);
            end else if (we_log[s0 + j] !== 3'(j)) begin
                errors++;
                $display("FAIL stall_we_addr%0d: got %0d expected %0d", j, we_log[s0 + j], j);
            end
        end
    endtask

    task automatic test_var_latency;
        logic [7:0] r;
        bit got;
        int m0, a0, v0;
        set_vectors(1, -1, 1);
        avec    = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6};
        lat_tab = '{1, 10, 4, 7, 2, 9, 5, 3};
        m0 = multi_viol; a0 = addr_err; v0 = vld_cnt;
        run_job(-1, r, got);
        checks++;
        if (r !== 8'd162 || !got) begin errors++; $display("FAIL varlat_result: got %0d expected 162", r); end
        checks++;
        if (multi_viol - m0 !== 0 || vld_cnt - v0 !== 8) begin
            errors++;
            $display("FAIL varlat_issue: overlaps %0d issues %0d expected 0 8",
                     multi_viol - m0, vld_cnt - v0);
        end
        checks++;
        if (addr_err - a0 !== 0) begin
            errors++; $display("FAIL varlat_addr_stable: got %0d errors expected 0", addr_err - a0);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [7:0] r;
        logic [34:0] ov;
        bit got;
        set_vectors(1, -1, 10);
        run_job(4, r, got);
        checks++;
        if (got !== 1'b0 || !bus.busy) begin
            errors++; $display("FAIL midrst_reach_wait: done %0d busy %0d expected 0 1", got, bus.busy);
        end
        areset = 1'b1;
        @(negedge aclk);
        ov = {bus.pe_aresetn, bus.pe_we, bus.pe_valid, bus.b_ready, bus.a_ready,
              bus.res_valid, bus.err, bus.busy, bus.pe_addr, bus.pe_din, bus.pe_ain,
              bus.res_data};
        checks++;
        if (ov !== 35'd0) begin
            errors++; $display("FAIL midrst_outputs: got %h expected 0", ov);
        end
        areset = 1'b0;
        @(negedge aclk);
        set_vectors(1, -1, 3);
        run_job(-1, r, got);
        checks++;
        if (r !== 8'd36 || !got) begin errors++; $display("FAIL midrst_rerun: got %0d expected 36", r); end
    endtask

`ifdef PE_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        logic [7:0] r;
        bit got;
        set_vectors(1, -1, 0);
        run_job(-1, r, got);
        checks++;
        if (!got || r !== 8'd0 || rec_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: done %0d res %0d err %0d expected 1 0 1", got, r, rec_err);
        end
        checks++;
        if (last_res_cyc - last_issue_cyc !== 64) begin
            errors++;
            $display("FAIL timeout_delay: got %0d expected 64", last_res_cyc - last_issue_cyc);
        end
        set_vectors(1, -1, 3);
        run_job(-1, r, got);
        checks++;
        if (r !== 8'd36 || rec_err !== 1'b0) begin
            errors++; $display("FAIL timeout_err_clear: res %0d err %0d expected 36 0", r, rec_err);
        end
    endtask
`endif

    initial begin
        bus.start   = 1'b0;
        bus.b_valid = 1'b0;
        bus.b_data  = 8'd0;
        bus.a_valid = 1'b0;
        bus.a_data  = 8'd0;
        areset      = 1'b1;
        set_vectors(1, -1, 3);
        test_reset;
        test_basic;
        test_back_to_back;
        test_stalled;
        test_var_latency;
        test_reset_mid_wait;
`ifdef PE_CTRL_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
